// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-organised data memory; sub-word stores are read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned requests instead of forcing natural alignment.
module lsu_mem_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned HALF = 16;
    localparam int unsigned BYTE = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        off_q;
    logic              byte_q;
    logic              word_q;
    logic              we_q;
    logic              uns_q;
    logic              mis_q;
    logic [HALF-1:0]   wdata_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_wd_q;

    logic              acc_word;
    logic              acc_half;
    logic              acc_mis;
    logic [XLEN-1:0]   acc_addr;
    logic              acc_full_wr;

    // Select the addressed lane of a word and extend it to XLEN.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] w,
        input logic [1:0]      off,
        input logic            is_byte,
        input logic            is_word,
        input logic            uns
    );
        logic [BYTE-1:0] b;
        logic [HALF-1:0] h;
        logic [XLEN-1:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        if (is_word) begin
            r = w;
        end else if (is_byte) begin
            r = uns ? {24'h0, b} : {{24{b[BYTE-1]}}, b};
        end else begin
            r = uns ? {16'h0, h} : {{16{h[HALF-1]}}, h};
        end
        return r;
    endfunction

    // Replace the addressed byte or half lane of the old word with store data.
    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0] old,
        input logic [1:0]      off,
        input logic            is_byte,
        input logic [HALF-1:0] wd
    );
        logic [XLEN-1:0] r;
        r = old;
        if (is_byte) begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = wd;
        end else begin
            r[15:0] = wd;
        end
        return r;
    endfunction

    // Request decode: alignment check (trap build) or forced natural alignment.
    always_comb begin
        acc_word = req_size[1];
        acc_half = (req_size == 2'b01);
`ifdef LSU_MISALIGN_TRAP_EN
        acc_mis  = (acc_half && req_addr[0]) || (acc_word && (req_addr[1:0] != 2'b00));
        acc_addr = req_addr;
`else
        acc_mis  = 1'b0;
        if (acc_word) begin
            acc_addr = {req_addr[31:2], 2'b00};
        end else if (acc_half) begin
            acc_addr = {req_addr[31:1], 1'b0};
        end else begin
            acc_addr = req_addr;
        end
`endif
        acc_full_wr = req_we && acc_word && !acc_mis;
    end

    assign req_ready = (state == S_IDLE) && !rst;
    assign mem_we    = mem_we_q && !rst;
    assign mem_wd    = mem_we ? mem_wd_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            off_q          <= '0;
            byte_q         <= 1'b0;
            word_q         <= 1'b0;
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            mis_q          <= 1'b0;
            wdata_q        <= '0;
            mem_we_q       <= 1'b0;
            mem_wd_q       <= '0;
            mem_addr       <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state    <= S_ACCESS;
                        off_q    <= acc_addr[1:0];
                        byte_q   <= (req_size == 2'b00);
                        word_q   <= acc_word;
                        we_q     <= req_we;
                        uns_q    <= req_unsigned;
                        mis_q    <= acc_mis;
                        wdata_q  <= req_wdata[HALF-1:0];
                        mem_addr <= {acc_addr[31:2], 2'b00};
                        // Word stores write during ACCESS, so arm the write here.
                        mem_we_q <= acc_full_wr;
                        mem_wd_q <= acc_full_wr ? req_wdata : '0;
                    end
                end
                S_ACCESS: begin
                    if (mis_q) begin
                        state          <= S_RESP;
                        mem_addr       <= '0;
                        rsp_valid      <= 1'b1;
                        rsp_rdata      <= '0;
                        rsp_misaligned <= 1'b1;
                    end else if (!we_q) begin
                        state     <= S_RESP;
                        mem_addr  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_extract(mem_rd, off_q, byte_q, word_q, uns_q);
                    end else if (word_q) begin
                        state     <= S_RESP;
                        mem_addr  <= '0;
                        mem_we_q  <= 1'b0;
                        mem_wd_q  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state    <= S_MERGE;
                        mem_we_q <= 1'b1;
                        mem_wd_q <= store_merge(mem_rd, off_q, byte_q, wdata_q);
                    end
                end
                S_MERGE: begin
                    state     <= S_RESP;
                    mem_addr  <= '0;
                    mem_we_q  <= 1'b0;
                    mem_wd_q  <= '0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
                default: begin
                    state          <= S_IDLE;
                    rsp_valid      <= 1'b0;
                    rsp_rdata      <= '0;
                    rsp_misaligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: memory model, reference model and per-cycle compare.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] dut_mem [16];
    logic [31:0] ref_mem [16];

    typedef struct packed { logic [31:0] rdata; logic mis; } rsp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t exp_rsp_q[$];
    wr_t  exp_wr_q[$];

    int tests = 0;
    int fails = 0;
    logic [31:0] last_rdata;
    logic        last_mis;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = dut_mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) dut_mem[mem_addr[5:2]] <= mem_wd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Reference model: byte-lane arithmetic on a word array.
    task automatic model_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output int wcyc);
        int          nbytes;
        int          off;
        logic        mis;
        logic [31:0] ea, old, mask, lanemask, v, nw;
        rsp_t        r;
        wr_t         w;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (a & 32'(nbytes - 1)) != 32'h0;
        ea  = a;
`else
        mis = 1'b0;
        ea  = a & ~32'(nbytes - 1);
`endif
        off      = int'(ea[1:0]);
        old      = ref_mem[ea[5:2]];
        lanemask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        mask     = lanemask << (8 * off);
        lat  = 2;
        wcyc = 0;
        if (mis) begin
            r.rdata = 32'h0; r.mis = 1'b1;
        end else if (!we) begin
            v = (old & mask) >> (8 * off);
            if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~lanemask;
            r.rdata = v; r.mis = 1'b0;
        end else begin
            nw = (old & ~mask) | ((wd << (8 * off)) & mask);
            ref_mem[ea[5:2]] = nw;
            w.addr = ea & ~32'h3; w.data = nw;
            exp_wr_q.push_back(w);
            r.rdata = 32'h0; r.mis = 1'b0;
            lat  = (nbytes == 4) ? 2 : 3;
            wcyc = (nbytes == 4) ? 1 : 2;
        end
        exp_rsp_q.push_back(r);
    endtask

    // One full transaction; checks response latency and write cycle relative to the accept edge.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        int lat, wcyc, n, seen_rsp, seen_wr;
        model_req(we, sz, uns, a, wd, lat, wcyc);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            flag_fail("accept_timeout");
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen_rsp = 0;
        seen_wr  = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_we && seen_wr == 0) seen_wr = c;
            if (rsp_valid && seen_rsp == 0) begin
                seen_rsp   = c;
                last_rdata = rsp_rdata;
                last_mis   = rsp_misaligned;
            end
        end
        check("rsp_latency", 32'(seen_rsp), 32'(lat));
        check("write_cycle", 32'(seen_wr), 32'(wcyc));
    endtask

    // Per-cycle compare of responses and memory writes against the model's queues.
    always @(negedge clk) begin : cmp
        rsp_t e;
        wr_t  w;
        if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
                flag_fail("unexpected_rsp");
            end else begin
                e = exp_rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_misaligned", 32'(rsp_misaligned), 32'(e.mis));
            end
        end
        if (mem_we) begin
            if (exp_wr_q.size() == 0) begin
                flag_fail("unexpected_write");
            end else begin
                w = exp_wr_q.pop_front();
                check("mem_addr", mem_addr, w.addr);
                check("mem_wd", mem_wd, w.data);
            end
        end
    end

    initial begin
        int accepts, last_i;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        last_rdata = 32'h0; last_mis = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_mem_we", 32'(mem_we), 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wd", mem_wd, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'h1);

        // Word store then load
        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("lit_mem4_word", dut_mem[4], 32'hDEAD_BEEF);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lit_load_word", last_rdata, 32'hDEAD_BEEF);

        // Byte read-modify-write
        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        xact(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
        check("lit_mem4_byte_rmw", dut_mem[4], 32'h11AA_3344);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lit_load_rmw", last_rdata, 32'h11AA_3344);

        // Load extraction patterns
        xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01);
        xact(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
        check("lit_lb_23", last_rdata, 32'hFFFF_FF80);
        xact(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        check("lit_lbu_23", last_rdata, 32'h0000_0080);
        xact(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        check("lit_lh_20", last_rdata, 32'h0000_7F01);
        xact(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("lit_lh_22", last_rdata, 32'hFFFF_80FF);
        xact(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        check("lit_lhu_22", last_rdata, 32'h0000_80FF);
        xact(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        check("lit_lb_21", last_rdata, 32'h0000_007F);
        xact(1'b0, 2'b11, 1'b1, 32'h20, 32'h0);
        check("lit_size3_word", last_rdata, 32'h80FF_7F01);

        // Halfword read-modify-write on the upper lane
        xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
        check("lit_mem8_half_rmw", dut_mem[8], 32'hBEEF_7F01);

        // Misaligned accesses
        xact(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        xact(1'b1, 2'b10, 1'b0, 32'h13, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lit_mis_flag", 32'(last_mis), 32'h1);
        check("lit_mis_mem4", dut_mem[4], 32'h11AA_3344);
`else
        check("lit_nomis_flag", 32'(last_mis), 32'h0);
        check("lit_nomis_mem4", dut_mem[4], 32'hCAFE_F00D);
`endif

        // Streaming loads with req_valid held high
        accepts = 0;
        last_i  = -10;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h23; req_wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            int lat, wcyc;
            if (i > 0) @(negedge clk);
            if (req_ready) begin
                if (accepts > 0) check("stream_gap", 32'(i - last_i), 32'd3);
                model_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, lat, wcyc);
                accepts++;
                last_i = i;
            end
        end
        req_valid = 1'b0;
        check("stream_accepts", 32'(accepts), 32'd4);
        repeat (4) @(negedge clk);
        check("stream_rsp_drained", 32'(exp_rsp_q.size()), 32'd0);

        // Reset during MERGE: no write, no response
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h55;
        begin
            int n;
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("merge_rst_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        check("merge_rst_ready_low", 32'(req_ready), 32'h0);
        check("merge_rst_no_rsp", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("merge_rst_ready_after", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);
        check("merge_rst_mem4", dut_mem[4], ref_mem[4]);

        // Reset in the same cycle as a request
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20;
        @(negedge clk);
        check("rst_valid_ready_low", 32'(req_ready), 32'h0);
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rst_valid_not_accepted", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);

        // Final memory agreement with the model
        check("final_mem4", dut_mem[4], ref_mem[4]);
        check("final_mem8", dut_mem[8], ref_mem[8]);
        check("final_wr_drained", 32'(exp_wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
